// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-side access stage driving the Memory d_* port.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being aligned down.
//
// state      | meaning
// S_IDLE     | waiting for a request, req_ready high
// S_LD_ADDR  | load address presented, memory registering the read
// S_LD_DATA  | read data valid on mem_rdata, response issued at the next edge
// S_ST_WAIT  | mem_wen held high until mem_ready or the timeout terminal count
// S_ERR      | illegal/misaligned request, error response at the next edge
module load_store_unit #(
    parameter int WORD_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [WORD_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wmask,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata,
    input  logic                mem_ready
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ADDR,
        S_LD_DATA,
        S_ST_WAIT,
        S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           off_q, off_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_LEN-1:0]  mem_addr_q, mem_addr_d;
    logic                 mem_wen_q, mem_wen_d;
    logic [WORD_LEN-1:0]  mem_wmask_q, mem_wmask_d;
    logic [WORD_LEN-1:0]  mem_wdata_q, mem_wdata_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic [WORD_LEN-1:0]  resp_rdata_q, resp_rdata_d;

    logic                 legal;
    logic                 go_err;
    logic [1:0]           eff_off;
    logic [3:0]           lane_mask;
    logic [WORD_LEN-1:0]  wmask_full;
    logic [WORD_LEN-1:0]  rd_shifted;
    logic [WORD_LEN-1:0]  load_ext;
`ifdef MISALIGN_TRAP_EN
    logic                 misaligned;
`endif

    // Request decode, used only on the accept edge.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !req_we;
            default:                legal = 1'b0;
        endcase

        eff_off   = 2'b00;
        lane_mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                eff_off   = req_addr[1:0];
                lane_mask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                eff_off   = {req_addr[1], 1'b0};
                lane_mask = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                eff_off   = 2'b00;
                lane_mask = 4'b1111;
            end
        endcase

        wmask_full = '0;
        for (int i = 0; i < 4; i++) begin
            wmask_full[8*i +: 8] = {8{lane_mask[i]}};
        end

`ifdef MISALIGN_TRAP_EN
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        go_err     = !legal || misaligned;
`else
        go_err     = !legal;
`endif
    end

    // Load extraction from the captured lane offset and size/sign.
    always_comb begin
        rd_shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_shifted[7]}},  rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_ext = {24'h000000, rd_shifted[7:0]};
            3'b101:  load_ext = {16'h0000,   rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wmask_d  = mem_wmask_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    funct3_d   = req_funct3;
                    off_d      = eff_off;
                    mem_addr_d = {req_addr[WORD_LEN-1:2], 2'b00};
                    if (go_err) begin
                        state_d = S_ERR;
                    end else if (req_we) begin
                        state_d     = S_ST_WAIT;
                        mem_wen_d   = 1'b1;
                        mem_wmask_d = wmask_full;
                        mem_wdata_d = req_wdata << {eff_off, 3'b000};
                        cnt_d       = CNT_LOAD;
                    end else begin
                        state_d = S_LD_ADDR;
                    end
                end
            end
            S_LD_ADDR: state_d = S_LD_DATA;
            S_LD_DATA: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
                state_d      = S_IDLE;
            end
            S_ST_WAIT: begin
                // mem_ready wins over the terminal count on the same edge.
                if (mem_ready) begin
                    mem_wen_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = S_IDLE;
                end else if (cnt_q == '0) begin
                    mem_wen_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ERR: begin
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            funct3_q     <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wmask_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wmask_q  <= mem_wmask_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against a byte-level memory model,
// with a simple Memory block (1-cycle registered read, 2-cycle RMW for partial writes).
module tb_load_store_unit;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks;
    int errors;

    load_store_unit #(.WORD_LEN(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h80FF7F01;
        return (32'(i) * 32'h01000193) ^ 32'h5A5A1234;
    endfunction

    // Memory block environment
    logic [31:0] mem [256];
    logic        wphase;
    logic        stall;
    logic        init_pulse;

    assign mem_ready = mem_wen && !stall && ((mem_wmask == 32'hFFFFFFFF) || wphase);

    always @(posedge clk) begin
        if (init_pulse) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            wphase <= 1'b0;
        end else begin
            mem_rdata <= mem[mem_addr[9:2]];
            if (mem_wen && mem_ready) begin
                mem[mem_addr[9:2]] <= (mem[mem_addr[9:2]] & ~mem_wmask) | (mem_wdata & mem_wmask);
                wphase <= 1'b0;
            end else begin
                wphase <= mem_wen;
            end
        end
    end

    // Reference model: what the core should observe
    logic [31:0] ref_mem [256];

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic stl,
                         output logic [31:0] e_rd, output logic e_er, output int e_lat,
                         output int e_wen, output logic [31:0] e_wm, output logic [31:0] e_wd);
        int   size;
        int   boff;
        int   off;
        int   idx;
        logic legal;
        logic err;
        logic [63:0] v;
        logic [31:0] w;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << f3[1:0];
        boff  = int'(addr % 4);
        off   = boff - (boff % size);
        idx   = int'(addr[9:2]);
        err   = !legal;
`ifdef MISALIGN_TRAP_EN
        if (legal && (addr % size) != 0) err = 1'b1;
`endif
        e_rd = 32'h0; e_er = 1'b0; e_lat = 0; e_wen = 0; e_wm = 32'h0; e_wd = 32'h0;
        if (err) begin
            e_er  = 1'b1;
            e_lat = 1;
        end else if (!we) begin
            w = ref_mem[idx];
            v = ({32'h0, w} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
            if (f3 < 3'd4 && size < 4 && v >= (64'd1 << (8 * size - 1)))
                v = v - (64'd1 << (8 * size));
            e_rd  = v[31:0];
            e_lat = 2;
        end else begin
            for (int b = 0; b < size; b++) e_wm = e_wm | (32'hFF << (8 * (off + b)));
            e_wd = wd << (8 * off);
            if (stl) begin
                e_er  = 1'b1;
                e_lat = TMO;
            end else begin
                for (int b = 0; b < size; b++) begin
                    w = ref_mem[idx];
                    w[8*(off+b) +: 8] = wd[8*b +: 8];
                    ref_mem[idx] = w;
                end
                e_lat = (size == 4) ? 1 : 2;
            end
            e_wen = e_lat;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int wen_cyc, output logic [31:0] wm, output logic [31:0] wdv);
        logic done;
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("resp_pulse_low", {31'h0, resp_valid}, 32'h0);
        lat = 0; wen_cyc = 0; done = 1'b0; rd = 32'h0; er = 1'b0; wm = 32'h0; wdv = 32'h0;
        while (!done && lat < 40) begin
            if (mem_wen) begin
                wen_cyc++;
                wm  = mem_wmask;
                wdv = mem_wdata;
            end
            @(posedge clk);
            #1;
            lat++;
            if (resp_valid) begin
                done = 1'b1;
                rd   = resp_rdata;
                er   = resp_err;
            end
        end
        chk("resp_seen", {31'h0, done}, 32'h1);
    endtask

    task automatic op(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input logic stl,
                      output logic [31:0] rd, output logic er, output int lat);
        logic [31:0] e_rd, e_wm, e_wd, wm, wdv;
        logic        e_er;
        int          e_lat, e_wen, wen_cyc;
        model(we, f3, addr, wd, stl, e_rd, e_er, e_lat, e_wen, e_wm, e_wd);
        stall = stl;
        run_req(we, f3, addr, wd, lat, rd, er, wen_cyc, wm, wdv);
        stall = 1'b0;
        chk({tag, "_lat"},   32'(lat), 32'(e_lat));
        chk({tag, "_rdata"}, rd, e_rd);
        chk({tag, "_err"},   {31'h0, er}, {31'h0, e_er});
        chk({tag, "_wen"},   32'(wen_cyc), 32'(e_wen));
        chk({tag, "_wen_after"}, {31'h0, mem_wen}, 32'h0);
        if (e_wen > 0) begin
            chk({tag, "_wmask"}, wm, e_wm);
            chk({tag, "_wdata"}, wdv, e_wd);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
        req_addr = 32'h0; req_wdata = 32'h0; stall = 1'b0; init_pulse = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        @(posedge clk);
        #1;
        init_pulse = 1'b0;
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr",   mem_addr,   32'h0);
        chk("rst_mem_wen",    {31'h0, mem_wen}, 32'h0);
        chk("rst_mem_wmask",  mem_wmask,  32'h0);
        chk("rst_mem_wdata",  mem_wdata,  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Byte loads from 0x80FF7F01
        op("lb_100", 1'b0, 3'b000, 32'h100, 32'h0, 1'b0, rd, er, lat);
        chk("lb_100_const", rd, 32'h00000001);
        op("lb_102", 1'b0, 3'b000, 32'h102, 32'h0, 1'b0, rd, er, lat);
        chk("lb_102_const", rd, 32'hFFFFFFFF);
        op("lbu_102", 1'b0, 3'b100, 32'h102, 32'h0, 1'b0, rd, er, lat);
        chk("lbu_102_const", rd, 32'h000000FF);
        chk("lbu_102_lat_const", 32'(lat), 32'd2);

        // Full-word store then partial byte store with RMW
        op("sw_104", 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0, rd, er, lat);
        chk("sw_104_lat_const", 32'(lat), 32'd1);
        op("lw_104", 1'b0, 3'b010, 32'h104, 32'h0, 1'b0, rd, er, lat);
        chk("lw_104_const", rd, 32'hDEADBEEF);
        op("sb_105", 1'b1, 3'b000, 32'h105, 32'h000000AA, 1'b0, rd, er, lat);
        chk("sb_105_lat_const", 32'(lat), 32'd2);
        op("lw_104b", 1'b0, 3'b010, 32'h104, 32'h0, 1'b0, rd, er, lat);
        chk("lw_104b_const", rd, 32'hDEADAAEF);

        // Misaligned word load
        op("lw_102", 1'b0, 3'b010, 32'h102, 32'h0, 1'b0, rd, er, lat);
`ifdef MISALIGN_TRAP_EN
        chk("lw_102_err_const", {31'h0, er}, 32'h1);
`else
        chk("lw_102_const", rd, 32'h80FF7F01);
`endif

        // Illegal funct3 and store timeout
        op("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, rd, er, lat);
        chk("ld_f3_011_err_const", {31'h0, er}, 32'h1);
        op("sb_timeout", 1'b1, 3'b000, 32'h10C, 32'h00000055, 1'b1, rd, er, lat);
        chk("sb_timeout_lat_const", 32'(lat), 32'(TMO));
        op("lw_10c", 1'b0, 3'b010, 32'h10C, 32'h0, 1'b0, rd, er, lat);

        // Reset during ST_WAIT of a half store: write abandoned
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h108; req_wdata = 32'h00001234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("sh_rst_wen_high", {31'h0, mem_wen}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("sh_rst_wen_low",  {31'h0, mem_wen}, 32'h0);
        chk("sh_rst_wmask",    mem_wmask, 32'h0);
        chk("sh_rst_ready",    {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op("lw_108_after_rst", 1'b0, 3'b010, 32'h108, 32'h0, 1'b0, rd, er, lat);
        chk("lw_108_old_const", rd, init_word(66));

        // Random traffic in a 64-byte window
        for (int n = 0; n < 80; n++) begin
            rwe   = 1'($urandom_range(0, 1));
            rf3   = 3'($urandom_range(0, 7));
            raddr = 32'h100 + 32'($urandom_range(0, 63));
            op("rnd", rwe, rf3, raddr, $urandom, 1'b0, rd, er, lat);
        end
        for (int n = 0; n < 16; n++) begin
            op("rnd_rb", 1'b0, 3'b010, 32'h100 + 32'(4 * n), 32'h0, 1'b0, rd, er, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
